program_counter_unit: RTL and testbench
=======================================

// Module: program_counter_unit
// PURPOSE
// - 16-bit 6502 program counter (PCL/PCH) for the NES CPU datapath; reads the ADL/ADH address buses and feeds PCL/PCH back as bus sources.
// - Each cycle: select next-PC source (bus load or hold), optionally increment by one with PCL->PCH carry, register the result.
// - PCL output is the PCL source of the address-low bus mux; PCH output goes to the address-high bus mux and data bus drivers.
// PARAMETERS
// - RESET_PC   16'h0000   PC value on reset; the reset vector is loaded later over ADL/ADH.
// PORTS
// - clk             in   1  system clock; all state updates on rising edge
// - rst             in   1  reset; asynchronous, active-high
// - RDY             in   1  1 = advance; 0 = freeze all state (stall)
// - ADL_PCL         in   1  load PCL select from ADL bus
// - PCL_PCL         in   1  recirculate PCL into PCL select
// - ADH_PCH         in   1  load PCH select from ADH bus
// - PCH_PCH         in   1  recirculate PCH into PCH select
// - I_PC            in   1  increment selected PC by one this cycle
// - ADL             in   8  address-low bus value
// - ADH             in   8  address-high bus value
// - Program_Counter_Low_Register_Out   out  8  registered PCL
// - Program_Counter_High_Register_Out  out  8  registered PCH
// - PCL_Carry       out  1  registered; 1 for one cycle after PCL wrapped FF->00 by increment
// - Select_Conflict out  1  registered; 1 for one cycle after ADL_PCL&PCL_PCL or ADH_PCH&PCH_PCH
// BEHAVIOUR
// - Reset (async, any time incl. mid-increment): PCH:PCL = RESET_PC, PCL_Carry = 0, Select_Conflict = 0.
// - Latency: one clock; values on bus/controls in cycle N appear on the outputs after edge N.
// - RDY=0: every register holds, including PCL_Carry and Select_Conflict; bus and control inputs are ignored.
// - PCL select: ADL_PCL ? ADL : PCL (ADL wins if both; neither = PCL, i.e. hold).
// - PCH select: ADH_PCH ? ADH : PCH (same priority rules).
// - Increment: {c, pcl_n} = pcl_sel + I_PC (9-bit); pch_n = pch_sel + c (8-bit, wraps).
// - Carry applies to the selected PCH, so a PCH load and a carry in the same cycle yield ADH+1.
// - FFFF + 1 = 0000; PCL_Carry=1 on that edge; no other flag.
// - PCL_Carry = c from the same edge; cleared on the next advancing edge without a wrap.
// - Select_Conflict is a bench/debug flag only; it never alters the datapath result.
// - Loads with I_PC=0 take the bus value exactly (JMP absolute). Loads with I_PC=1 take bus+1 (RTS fix-up).
// STRUCTURE
// - Shared cpu package: constant PC_RESET_DEFAULT (16'h0000); typedef pc_t = logic [15:0].
// - The same package holds typedef pc_ctrl_t as a packed struct {ADL_PCL, PCL_PCL, ADH_PCH, PCH_PCH, I_PC}, shared with the control decoder.
// - One sub-module: pc_half_incrementer (8-bit select mux + incrementer, carry in/out), instantiated for PCL and PCH.
// - Top-level module: one always_ff for registers and flags, combinational glue only.
// TESTING
// - Reset: assert rst mid-cycle with I_PC=1 -> outputs 0000, flags 0, asynchronously; release -> holds 0000 with all controls 0.
// - Sequential fetch: PC=80FE, PCL_PCL=PCH_PCH=I_PC=1 for 3 clocks -> 80FF, 8100 (PCL_Carry=1), 8101 (PCL_Carry=0).
// - Vector/JMP load: ADL=FC, ADH=FF, ADL_PCL=ADH_PCH=1, I_PC=0 -> FFFC. Same with I_PC=1 and ADL=FF, ADH=12 -> 1300, PCL_Carry=1.
// - Wrap: PC=FFFF, recirculate+I_PC -> 0000, PCL_Carry=1.
// - Stall: PC=1234, RDY=0 with I_PC=1 and ADL_PCL=1 for 4 clocks -> stays 1234, flags frozen; RDY=1 -> 1235.
// - Conflict: ADL_PCL=PCL_PCL=1, ADL=55, PC=2000, I_PC=0 -> PC=2055, Select_Conflict=1 for exactly one cycle.

Source files
------------

// File: rtl/program_counter_unit_pkg.sv
`default_nettype none
// ============================================================================
// program_counter_unit_pkg : shared CPU types for the PC datapath and decoder
// Revision: 1.0
// ============================================================================
package program_counter_unit_pkg;

  typedef logic [15:0] pc_t;

  localparam pc_t PC_RESET_DEFAULT = 16'h0000;

  // Field order matches the control decoder's microword layout.
  typedef struct packed {
    logic adl_pcl;
    logic pcl_pcl;
    logic adh_pch;
    logic pch_pch;
    logic i_pc;
  } pc_ctrl_t;

  function automatic logic select_conflict(input pc_ctrl_t ctrl);
    return (ctrl.adl_pcl & ctrl.pcl_pcl) | (ctrl.adh_pch & ctrl.pch_pch);
  endfunction

endpackage : program_counter_unit_pkg
`default_nettype wire

// File: rtl/program_counter_unit_half_incrementer.sv
`default_nettype none
// ============================================================================
// pc_half_incrementer : 8-bit bus/hold select followed by a +carry-in adder
// Revision: 1.0
// ============================================================================
module pc_half_incrementer
  import program_counter_unit_pkg::*;
(
  input  logic       i_load,
  input  logic [7:0] i_bus,
  input  logic [7:0] i_cur,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  logic [7:0] w_sel;
  logic [8:0] w_sum;

  // Recirculation and "no select" both mean hold, so only the load line matters.
  assign w_sel  = i_load ? i_bus : i_cur;
  assign w_sum  = {1'b0, w_sel} + {8'd0, i_cin};
  assign o_sum  = w_sum[7:0];
  assign o_cout = w_sum[8];

endmodule : pc_half_incrementer
`default_nettype wire

// File: rtl/program_counter_unit.sv
`default_nettype none
// ============================================================================
// program_counter_unit : 6502 PCL/PCH register pair with bus load and +1
// Revision: 1.0
// ============================================================================
module program_counter_unit
  import program_counter_unit_pkg::*;
#(
  parameter pc_t RESET_PC = PC_RESET_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RDY,
  input  logic       ADL_PCL,
  input  logic       PCL_PCL,
  input  logic       ADH_PCH,
  input  logic       PCH_PCH,
  input  logic       I_PC,
  input  logic [7:0] ADL,
  input  logic [7:0] ADH,
  output logic [7:0] Program_Counter_Low_Register_Out,
  output logic [7:0] Program_Counter_High_Register_Out,
  output logic       PCL_Carry,
  output logic       Select_Conflict
);

  pc_ctrl_t   w_ctrl;
  logic [7:0] w_pcl_next;
  logic [7:0] w_pch_next;
  logic       w_pcl_cout;
  logic       w_pch_cout_unused;
  logic       w_conflict;

  pc_t        r_pc;
  logic       r_carry;
  logic       r_conflict;

  assign w_ctrl = '{adl_pcl: ADL_PCL, pcl_pcl: PCL_PCL,
                    adh_pch: ADH_PCH, pch_pch: PCH_PCH, i_pc: I_PC};

  assign w_conflict = select_conflict(w_ctrl);

  pc_half_incrementer u_pcl (
    .i_load (w_ctrl.adl_pcl),
    .i_bus  (ADL),
    .i_cur  (r_pc[7:0]),
    .i_cin  (w_ctrl.i_pc),
    .o_sum  (w_pcl_next),
    .o_cout (w_pcl_cout)
  );

  // The low-byte carry ripples into whichever high byte was selected, so ADH loads also see +1.
  pc_half_incrementer u_pch (
    .i_load (w_ctrl.adh_pch),
    .i_bus  (ADH),
    .i_cur  (r_pc[15:8]),
    .i_cin  (w_pcl_cout),
    .o_sum  (w_pch_next),
    .o_cout (w_pch_cout_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_carry    <= 1'b0;
      r_conflict <= 1'b0;
    end else if (RDY) begin
      r_pc       <= {w_pch_next, w_pcl_next};
      r_carry    <= w_pcl_cout;
      r_conflict <= w_conflict;
    end
  end

  assign Program_Counter_Low_Register_Out  = r_pc[7:0];
  assign Program_Counter_High_Register_Out = r_pc[15:8];
  assign PCL_Carry                         = r_carry;
  assign Select_Conflict                   = r_conflict;

endmodule : program_counter_unit
`default_nettype wire

// File: tb/tb_program_counter_unit.sv
`default_nettype none
// ============================================================================
// tb_program_counter_unit : directed and randomized checks of program_counter_unit
// Revision: 1.0
// ============================================================================
module tb_program_counter_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RDY = 1'b1;
  logic       ADL_PCL = 1'b0, PCL_PCL = 1'b0, ADH_PCH = 1'b0, PCH_PCH = 1'b0, I_PC = 1'b0;
  logic [7:0] ADL = 8'h00, ADH = 8'h00;
  logic [7:0] pcl_o, pch_o;
  logic       carry_o, conf_o;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_pc    = 16'h0000;
  logic        m_carry = 1'b0;
  logic        m_conf  = 1'b0;

  always #5 clk = ~clk;

  program_counter_unit #(.RESET_PC(16'h0000)) dut (
    .clk                               (clk),
    .rst                               (rst),
    .RDY                               (RDY),
    .ADL_PCL                           (ADL_PCL),
    .PCL_PCL                           (PCL_PCL),
    .ADH_PCH                           (ADH_PCH),
    .PCH_PCH                           (PCH_PCH),
    .I_PC                              (I_PC),
    .ADL                               (ADL),
    .ADH                               (ADH),
    .Program_Counter_Low_Register_Out  (pcl_o),
    .Program_Counter_High_Register_Out (pch_o),
    .PCL_Carry                         (carry_o),
    .Select_Conflict                   (conf_o)
  );

  // Drive one cycle of controls, clock it, and advance the reference model.
  task automatic step(input logic rdy, input logic a_l, input logic p_l,
                      input logic a_h, input logic p_h, input logic ipc,
                      input logic [7:0] adl, input logic [7:0] adh);
    int lo, hi;
    RDY = rdy; ADL_PCL = a_l; PCL_PCL = p_l; ADH_PCH = a_h; PCH_PCH = p_h;
    I_PC = ipc; ADL = adl; ADH = adh;
    @(posedge clk);
    if (rdy) begin
      lo = (a_l ? int'(adl) : int'(m_pc[7:0])) + int'(ipc);
      hi = ((a_h ? int'(adh) : int'(m_pc[15:8])) + (lo > 255 ? 1 : 0)) % 256;
      m_carry = (lo > 255);
      m_pc    = 16'((hi * 256) + (lo % 256));
      m_conf  = (a_l & p_l) | (a_h & p_h);
    end
    #1;
  endtask

  task automatic load_pc(input logic [15:0] v);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, v[7:0], v[15:8]);
  endtask

  task automatic test_reset();
    total++;
    if ({pch_o, pcl_o, carry_o, conf_o} !== 18'h0) begin
      bad++; $display("FAIL reset_init: got pc=%h c=%b x=%b want 0000/0/0", {pch_o, pcl_o}, carry_o, conf_o);
    end
    rst = 1'b0;
    load_pc(16'hABFF);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h00);
    // Mid-cycle async reset while an increment is being requested.
    #2 rst = 1'b1;
    #1;
    total++;
    if ({pch_o, pcl_o, carry_o, conf_o} !== 18'h0) begin
      bad++; $display("FAIL reset_async: got pc=%h c=%b x=%b want 0000/0/0", {pch_o, pcl_o}, carry_o, conf_o);
    end
    m_pc = 16'h0000; m_carry = 1'b0; m_conf = 1'b0;
    @(negedge clk) rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'hA5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'hA5);
    total++;
    if ({pch_o, pcl_o, carry_o, conf_o} !== 18'h0) begin
      bad++; $display("FAIL reset_hold: got pc=%h c=%b x=%b want 0000/0/0", {pch_o, pcl_o}, carry_o, conf_o);
    end
  endtask

  task automatic test_fetch();
    logic [15:0] exp_pc [3] = '{16'h80FF, 16'h8100, 16'h8101};
    logic        exp_c  [3] = '{1'b0, 1'b1, 1'b0};
    load_pc(16'h80FE);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
      total++;
      if ({pch_o, pcl_o} !== exp_pc[i] || carry_o !== exp_c[i]) begin
        bad++; $display("FAIL fetch[%0d]: got pc=%h c=%b want pc=%h c=%b", i, {pch_o, pcl_o}, carry_o, exp_pc[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_jmp();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFC, 8'hFF);
    total++;
    if ({pch_o, pcl_o} !== 16'hFFFC || carry_o !== 1'b0) begin
      bad++; $display("FAIL jmp_vector: got pc=%h c=%b want FFFC 0", {pch_o, pcl_o}, carry_o);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h12);
    total++;
    if ({pch_o, pcl_o} !== 16'h1300 || carry_o !== 1'b1) begin
      bad++; $display("FAIL rts_fixup: got pc=%h c=%b want 1300 1", {pch_o, pcl_o}, carry_o);
    end
  endtask

  task automatic test_wrap();
    load_pc(16'hFFFF);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    total++;
    if ({pch_o, pcl_o} !== 16'h0000 || carry_o !== 1'b1 || conf_o !== 1'b0) begin
      bad++; $display("FAIL wrap: got pc=%h c=%b x=%b want 0000 1 0", {pch_o, pcl_o}, carry_o, conf_o);
    end
  endtask

  task automatic test_stall();
    // Load with a select conflict so the frozen flag value is non-zero.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h34, 8'h12);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
      total++;
      if ({pch_o, pcl_o} !== 16'h1234 || conf_o !== 1'b1 || carry_o !== 1'b0) begin
        bad++; $display("FAIL stall[%0d]: got pc=%h c=%b x=%b want 1234 0 1", i, {pch_o, pcl_o}, carry_o, conf_o);
      end
    end
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    total++;
    if ({pch_o, pcl_o} !== 16'h1235 || conf_o !== 1'b0) begin
      bad++; $display("FAIL stall_release: got pc=%h x=%b want 1235 0", {pch_o, pcl_o}, conf_o);
    end
  endtask

  task automatic test_conflict();
    load_pc(16'h2000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 8'h77);
    total++;
    if ({pch_o, pcl_o} !== 16'h2055 || conf_o !== 1'b1) begin
      bad++; $display("FAIL conflict_set: got pc=%h x=%b want 2055 1", {pch_o, pcl_o}, conf_o);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    total++;
    if ({pch_o, pcl_o} !== 16'h2055 || conf_o !== 1'b0) begin
      bad++; $display("FAIL conflict_clear: got pc=%h x=%b want 2055 0", {pch_o, pcl_o}, conf_o);
    end
  endtask

  task automatic test_random();
    logic [7:0] adl, adh;
    for (int i = 0; i < 300; i++) begin
      adl = 8'($urandom);
      adh = 8'($urandom);
      // Bias the low bus toward FF so carries and wraps occur often.
      if ($urandom_range(0, 3) == 0) adl = 8'hFF;
      if ($urandom_range(0, 7) == 0) adh = 8'hFF;
      step($urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), adl, adh);
      total++;
      if ({pch_o, pcl_o} !== m_pc || carry_o !== m_carry || conf_o !== m_conf) begin
        bad++;
        $display("FAIL random[%0d]: got pc=%h c=%b x=%b want pc=%h c=%b x=%b",
                 i, {pch_o, pcl_o}, carry_o, conf_o, m_pc, m_carry, m_conf);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_fetch();
    test_jmp();
    test_wrap();
    test_stall();
    test_conflict();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_program_counter_unit
`default_nettype wire
